// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a word-wide data memory.
// Sub-word stores are done as read-modify-write; loads are lane-extracted and extended.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_i,
  input  logic [31:0] mem_data_o
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state;
  state_t      state_next;

  logic        we_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rbuf_q;
  logic        err_q;

  logic        req_err;
  logic        handshake;
  logic [31:0] word_addr;
  logic [31:0] merged;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;

  // Misalignment and reserved-size detection on the incoming request.
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = (req_addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
  end

  assign handshake = req_valid && (state == IDLE);
  assign word_addr = {addr_q[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            state_next = RESP;
          end else if (req_we && (req_size == 2'b10)) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD:      state_next = we_q ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else if (handshake) begin
      we_q       <= req_we;
      size_q     <= req_size;
      unsigned_q <= req_unsigned;
      addr_q     <= req_addr;
      wdata_q    <= req_wdata;
      err_q      <= req_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbuf_q <= 32'h0;
    end else if (state == RD) begin
      rbuf_q <= mem_data_o;
    end
  end

  // Store merge: sub-word data overwrites its lane in the word read during RD.
  always_comb begin
    merged = rbuf_q;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  assign byte_sel = rbuf_q[{addr_q[1:0], 3'b000} +: 8];
  assign half_sel = rbuf_q[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    load_val = rbuf_q;
    case (size_q)
      2'b00:   load_val = {{24{~unsigned_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{~unsigned_q & half_sel[15]}}, half_sel};
      default: load_val = rbuf_q;
    endcase
  end

  // Memory-side outputs decode only registered state, never the live request.
  always_comb begin
    req_ready  = (state == IDLE);
    mem_ren    = 1'b0;
    mem_wen    = 1'b0;
    mem_addr   = 32'h0;
    mem_data_i = 32'h0;
    case (state)
      RD: begin
        mem_ren  = 1'b1;
        mem_addr = word_addr;
      end
      WR: begin
        mem_wen    = 1'b1;
        mem_addr   = word_addr;
        mem_data_i = merged;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
    end else begin
      resp_valid <= (state == RESP);
      resp_err   <= (state == RESP) && err_q;
      resp_rdata <= ((state == RESP) && !err_q && !we_q) ? load_val : 32'h0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a negedge-commit memory model.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;

  logic [31:0] mem [0:255];
  int          checks;
  int          failures;

  mem_access_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_ren      (mem_ren),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_data_i   (mem_data_i),
    .mem_data_o   (mem_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_data_o = mem[mem_addr[9:2]];

  always @(negedge clk) begin
    if (mem_wen) mem[mem_addr[9:2]] <= mem_data_i;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One request; latency counts cycles after the handshake edge until resp_valid.
  task automatic applyStimulus(input string name, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                               input int exp_lat, input int exp_ren, input int exp_wen,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input logic [31:0] exp_wdat);
    int          lat;
    int          rens;
    int          wens;
    logic [31:0] wdat;
    logic [31:0] rdata;
    logic        err;
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_we       = ~we;
    req_size     = ~size;
    req_unsigned = ~uns;
    req_addr     = 32'hFFFF_FFFF;
    req_wdata    = $urandom;
    lat = 99; rens = 0; wens = 0; wdat = 32'h0; rdata = 32'h0; err = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_ren && mem_wen) checkOutput({name, ".ren_wen_overlap"}, 32'd1, 32'd0);
      if (mem_ren) rens++;
      if (mem_wen) begin
        wens++;
        wdat = mem_data_i;
      end
      if (resp_valid) begin
        lat   = i;
        rdata = resp_rdata;
        err   = resp_err;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput({name, ".latency"}, lat, exp_lat);
    checkOutput({name, ".ren_pulses"}, rens, exp_ren);
    checkOutput({name, ".wen_pulses"}, wens, exp_wen);
    checkOutput({name, ".rdata"}, rdata, exp_rdata);
    checkOutput({name, ".err"}, {31'h0, err}, {31'h0, exp_err});
    checkOutput({name, ".wdata"}, wdat, exp_wdat);
  endtask

  initial begin
    int hs2;
    int wens;
    int resps;
    checks = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[64] = 32'h8899AABB;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.ready", {31'h0, req_ready}, 32'd1);
    checkOutput("reset.resp_valid", {31'h0, resp_valid}, 32'd0);
    checkOutput("reset.resp_rdata", resp_rdata, 32'h0);
    checkOutput("reset.mem_ren_wen", {30'h0, mem_ren, mem_wen}, 32'd0);
    checkOutput("reset.mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("lb_102", 1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 2, 1, 0, 32'hFFFFFF99, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("idle.resp_valid", {31'h0, resp_valid}, 32'd0);
    checkOutput("idle.resp_rdata", resp_rdata, 32'h0);

    applyStimulus("sb_101", 1'b1, 2'b00, 1'b0, 32'h101, 32'hABCDEF11, 3, 1, 1, 32'h0, 1'b0, 32'h889911BB);
    checkOutput("sb_101.mem", mem[64], 32'h889911BB);
    applyStimulus("lw_100", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 2, 1, 0, 32'h889911BB, 1'b0, 32'h0);
    applyStimulus("sh_100", 1'b1, 2'b01, 1'b0, 32'h100, 32'h55551234, 3, 1, 1, 32'h0, 1'b0, 32'h88991234);
    applyStimulus("lhu_100", 1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 2, 1, 0, 32'h00001234, 1'b0, 32'h0);
    applyStimulus("lh_102", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 2, 1, 0, 32'hFFFF8899, 1'b0, 32'h0);
    applyStimulus("lbu_103", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 2, 1, 0, 32'h00000088, 1'b0, 32'h0);
    applyStimulus("sw_104", 1'b1, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF, 2, 0, 1, 32'h0, 1'b0, 32'hDEADBEEF);
    applyStimulus("sh_106", 1'b1, 2'b01, 1'b0, 32'h106, 32'hFFFF5678, 3, 1, 1, 32'h0, 1'b0, 32'h5678BEEF);
    applyStimulus("lb_104", 1'b0, 2'b00, 1'b0, 32'h104, 32'h0, 2, 1, 0, 32'hFFFFFFEF, 1'b0, 32'h0);

    applyStimulus("err_lw_103", 1'b0, 2'b10, 1'b0, 32'h103, 32'h0, 1, 0, 0, 32'h0, 1'b1, 32'h0);
    applyStimulus("err_lh_101", 1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 1, 0, 0, 32'h0, 1'b1, 32'h0);
    applyStimulus("err_size3", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1, 0, 0, 32'h0, 1'b1, 32'h0);
    applyStimulus("err_sw_102", 1'b1, 2'b10, 1'b0, 32'h102, 32'h12345678, 1, 0, 0, 32'h0, 1'b1, 32'h0);
    checkOutput("err_sw_102.mem", mem[64], 32'h88991234);

    // Back-to-back word stores with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h200; req_wdata = 32'h11112222;
    @(posedge clk);
    #1;
    req_addr = 32'h204; req_wdata = 32'h33334444;
    hs2 = -1; wens = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_wen) wens++;
      if (req_ready && req_valid && hs2 < 0) hs2 = i;
      @(posedge clk);
      #1;
      if (hs2 >= 0) req_valid = 1'b0;
    end
    checkOutput("b2b.second_handshake", hs2, 32'd2);
    checkOutput("b2b.wen_pulses", wens, 32'd2);
    checkOutput("b2b.mem0", mem[128], 32'h11112222);
    checkOutput("b2b.mem1", mem[129], 32'h33334444);

    // Reset pulsed during the write cycle.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h180; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("rst.wen_before", {31'h0, mem_wen}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst.wen_drop", {31'h0, mem_wen}, 32'd0);
    checkOutput("rst.ready_in_reset", {31'h0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    resps = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) resps++;
    end
    checkOutput("rst.no_resp", resps, 32'd0);
    checkOutput("rst.ready_after", {31'h0, req_ready}, 32'd1);
    checkOutput("rst.mem_untouched", mem[96], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
